// File: rtl/mc_proc_pkg.sv
// Shared definitions for the multi-cycle MIPS32 core: FSM states, opcode and
// funct constants, ALU control codes and the per-state control strobe table.
package mc_proc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_IMMWB, S_MEMRD,
    S_MEMWB, S_MEMWR, S_BRANCH, S_JAL, S_JR, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd6, ALU_SLT = 4'd7
  } alu_ctrl_t;

  // Which operand pair feeds the shared ALU in the current state.
  typedef enum logic [1:0] {ASEL_BRTGT, ASEL_RTYPE, ASEL_ADDR} alu_sel_t;
  typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} rf_dst_t;
  typedef enum logic [1:0] {SRC_ALUOUT, SRC_MDR, SRC_PC} rf_src_t;
  typedef enum logic [2:0] {PC_HOLD, PC_INC, PC_BRANCH, PC_JUMP, PC_REG} pc_src_t;

  typedef struct packed {
    logic     mem_re;
    logic     mem_we;
    logic     iord;       // memory address from ALUOut instead of PC
    logic     ir_write;   // IR and PC+4 update, qualified by mem_ready
    logic     ab_write;
    logic     alu_write;
    alu_sel_t alu_sel;
    logic     mdr_write;  // qualified by mem_ready
    logic     rf_write;
    rf_dst_t  rf_dst;
    rf_src_t  rf_src;
    pc_src_t  pc_src;
  } ctrl_t;

  function automatic logic is_alu_funct(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

  function automatic alu_ctrl_t funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Control strobes asserted while the FSM sits in state s.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_re = 1'b1; c.ir_write = 1'b1; c.pc_src = PC_INC; end
      S_DECODE: begin c.ab_write = 1'b1; c.alu_write = 1'b1; c.alu_sel = ASEL_BRTGT; end
      S_EXEC:   begin c.alu_write = 1'b1; c.alu_sel = ASEL_RTYPE; end
      S_ALUWB:  begin c.rf_write = 1'b1; c.rf_dst = DST_RD; c.rf_src = SRC_ALUOUT; end
      S_MEMADR: begin c.alu_write = 1'b1; c.alu_sel = ASEL_ADDR; end
      S_IMMWB:  begin c.rf_write = 1'b1; c.rf_dst = DST_RT; c.rf_src = SRC_ALUOUT; end
      S_MEMRD:  begin c.mem_re = 1'b1; c.iord = 1'b1; c.mdr_write = 1'b1; end
      S_MEMWB:  begin c.rf_write = 1'b1; c.rf_dst = DST_RT; c.rf_src = SRC_MDR; end
      S_MEMWR:  begin c.mem_we = 1'b1; c.iord = 1'b1; end
      S_BRANCH: c.pc_src = PC_BRANCH;
      S_JAL:    begin c.rf_write = 1'b1; c.rf_dst = DST_RA; c.rf_src = SRC_PC; c.pc_src = PC_JUMP; end
      S_JR:     c.pc_src = PC_REG;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_processor_if.sv
// Shared instruction/data memory port with a single ready handshake.
interface mc_processor_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_addr, mem_wdata, mem_re, mem_we,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_addr, mem_wdata, mem_re, mem_we,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/alu.sv
// 32-bit ALU shared with the single-cycle core; wrap-around arithmetic.
module alu
  import mc_proc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_ctrl_t   ctrl,
  output logic [31:0] y
);

  // Operation select.
  always_comb begin
    case (ctrl)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {31'b0, $signed(a) < $signed(b)};
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control: state register, next-state logic and registered
// control strobes. The retire pulse exists only with MC_PROC_PERF_CNT_EN.
module mc_control_fsm
  import mc_proc_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output ctrl_t      ctrl,
  output logic       illegal
`ifdef MC_PROC_PERF_CNT_EN
  ,
  output logic       retire
`endif
);

  state_t state;
  state_t next;
  logic   illegal_op;

  // Next-state selection; mem_ready only matters in the memory states.
  // NOTE: every output of this block is given a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next       = state;
    illegal_op = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_JR)         next = S_JR;
            else if (is_alu_funct(funct)) next = S_EXEC;
            else                          illegal_op = 1'b1;
          end
          OP_ADDI, OP_LW, OP_SW: next = S_MEMADR;
          OP_BEQ:  next = S_BRANCH;
          OP_JAL:  next = S_JAL;
          default: illegal_op = 1'b1;
        endcase
        if (illegal_op) next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
      end
      S_EXEC:   next = S_ALUWB;
      S_MEMADR: begin
        if (opcode == OP_LW)      next = S_MEMRD;
        else if (opcode == OP_SW) next = S_MEMWR;
        else                      next = S_IMMWB;
      end
      S_MEMRD:  if (mem_ready) next = S_MEMWB;
      S_MEMWR:  if (mem_ready) next = S_FETCH;
      S_ALUWB, S_IMMWB, S_MEMWB, S_BRANCH, S_JAL, S_JR: next = S_FETCH;
      S_HALT:   next = S_HALT;
      default:  next = S_FETCH;
    endcase
  end

`ifdef MC_PROC_PERF_CNT_EN
  assign retire = (state != S_FETCH) && (next == S_FETCH);
`endif

  // State register with strobes registered for the state being entered.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      ctrl    <= ctrl_for(S_FETCH);
      illegal <= 1'b0;
    end else begin
      state <= next;
      ctrl  <= ctrl_for(next);
      if (illegal_op) illegal <= 1'b1;
    end
  end

endmodule

// File: rtl/register_block.sv
// 32 x 32 register file: two combinational read ports, one write port, r0 = 0.
module register_block (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];

  // Write port; writes to r0 are dropped.
  // NOTE: the array has no reset so it maps onto RAM/flop arrays without reset muxes; software initialises registers.
  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) regs[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/mc_processor.sv
// Multi-cycle MIPS32 core with a shared instruction/data memory port.
// Optional feature: define MC_PROC_PERF_CNT_EN to add cycle_cnt/instret_cnt.
module mc_processor
  import mc_proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  mc_processor_if.master      mem,
  output logic                illegal
`ifdef MC_PROC_PERF_CNT_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instret_cnt
`endif
);

  logic [31:0] pc, ir, a_reg, b_reg, alu_out, mdr;
  logic [31:0] simm, alu_a, alu_b, alu_y, rd1, rd2, rf_wd;
  logic [4:0]  rf_wa;
  alu_ctrl_t   alu_op;
  ctrl_t       ctrl;
`ifdef MC_PROC_PERF_CNT_EN
  logic        retire;
`endif

  assign simm = {{16{ir[15]}}, ir[15:0]};

  mc_control_fsm #(.HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .opcode    (ir[31:26]),
    .funct     (ir[5:0]),
    .mem_ready (mem.mem_ready),
    .ctrl      (ctrl),
    .illegal   (illegal)
`ifdef MC_PROC_PERF_CNT_EN
    ,
    .retire    (retire)
`endif
  );

  // Memory port is driven purely from registers (Moore).
  assign mem.mem_addr  = ctrl.iord ? alu_out : pc;
  assign mem.mem_wdata = b_reg;
  assign mem.mem_re    = ctrl.mem_re;
  assign mem.mem_we    = ctrl.mem_we;

  // ALU operand and operation selection.
  always_comb begin
    alu_a  = a_reg;
    alu_b  = simm;
    alu_op = ALU_ADD;
    case (ctrl.alu_sel)
      ASEL_BRTGT: begin alu_a = pc; alu_b = {simm[29:0], 2'b00}; end
      ASEL_RTYPE: begin alu_b = b_reg; alu_op = funct_to_alu(ir[5:0]); end
      default:    alu_b = simm;
    endcase
  end

  alu u_alu (.a(alu_a), .b(alu_b), .ctrl(alu_op), .y(alu_y));

  // Register-file write address and data selection.
  always_comb begin
    rf_wa = ir[15:11];
    rf_wd = alu_out;
    case (ctrl.rf_dst)
      DST_RT:  rf_wa = ir[20:16];
      DST_RA:  rf_wa = 5'd31;
      default: rf_wa = ir[15:11];
    endcase
    case (ctrl.rf_src)
      SRC_MDR: rf_wd = mdr;
      SRC_PC:  rf_wd = pc;
      default: rf_wd = alu_out;
    endcase
  end

  register_block u_rf (
    .clk (clk),
    .we  (ctrl.rf_write),
    .ra1 (ir[25:21]),
    .ra2 (ir[20:16]),
    .wa  (rf_wa),
    .wd  (rf_wd),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  // Architectural and internal datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= 32'd0;
      a_reg   <= 32'd0;
      b_reg   <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
    end else begin
      if (ctrl.ir_write && mem.mem_ready)  ir <= mem.mem_rdata;
      if (ctrl.mdr_write && mem.mem_ready) mdr <= mem.mem_rdata;
      if (ctrl.ab_write) begin
        a_reg <= rd1;
        b_reg <= rd2;
      end
      if (ctrl.alu_write) alu_out <= alu_y;
      case (ctrl.pc_src)
        PC_INC:    if (mem.mem_ready) pc <= pc + 32'd4;
        PC_BRANCH: if (a_reg == b_reg) pc <= alu_out;
        PC_JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
        PC_REG:    pc <= a_reg;
        default:   pc <= pc;
      endcase
    end
  end

`ifdef MC_PROC_PERF_CNT_EN
  // Free-running cycle and retired-instruction counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mc_processor.md
# mc_processor

Multi-cycle MIPS32 core: the next generation of the team's single-cycle processor, sharing one memory port for instruction and data through a ready handshake. It executes one instruction over 3–5 states plus memory wait cycles, reusing the existing `alu` and `register_block`. It adds variable-latency memory support, a configurable reset vector and illegal-opcode handling.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `HALT_ON_ILLEGAL`, default 1: 1 means an illegal opcode halts the core; 0 means it retires as a NOP.
- `clk` input 1: clock, rising edge. One clock domain.
- `reset` input 1: asynchronous, active-high reset.
- `mem_addr` output 32: byte address for fetch, load or store.
- `mem_wdata` output 32: store data.
- `mem_re` output 1: read request.
- `mem_we` output 1: write request.
- `mem_rdata` input 32: read data, valid in the cycle `mem_ready`=1.
- `mem_ready` input 1: completes the pending request.
- `illegal` output 1: sticky, set on an unsupported opcode or funct.
- `cycle_cnt` output 32: present only with `MC_PROC_PERF_CNT_EN`.
- `instret_cnt` output 32: present only with `MC_PROC_PERF_CNT_EN`.

## Operation
- Supported instructions: add, sub, and, or, slt (R-type); addi, lw, sw, beq, jal; jr (R-type, funct 0x08).
- Internal registers: PC, IR, A, B, ALUOut, MDR.
- FETCH: `mem_re`=1, `mem_addr`=PC. On `mem_ready`: IR<=`mem_rdata`, PC<=PC+4, go to DECODE.
- DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=PC+(SignImm<<2). Next state by opcode:
  - R-type → EXEC; jr → JR.
  - lw, sw, addi → MEMADR.
  - beq → BRANCH; jal → JAL.
  - Anything else → HALT if `HALT_ON_ILLEGAL`, else FETCH. `illegal` is set in both cases.
- EXEC: ALUOut<=A op B → ALUWB. ALUWB: rf[rd]<=ALUOut → FETCH.
- MEMADR: ALUOut<=A+SignImm. Then lw → MEMRD, sw → MEMWR, addi → IMMWB.
- IMMWB: rf[rt]<=ALUOut → FETCH.
- MEMRD: `mem_re`=1, `mem_addr`=ALUOut. On `mem_ready`: MDR<=`mem_rdata` → MEMWB.
- MEMWB: rf[rt]<=MDR → FETCH.
- MEMWR: `mem_we`=1, `mem_addr`=ALUOut, `mem_wdata`=B. On `mem_ready` → FETCH.
- BRANCH: if A==B, PC<=ALUOut → FETCH.
- JAL: rf[31]<=PC (already PC+4); PC<={PC[31:28], IR[25:0], 2'b00} → FETCH.
- JR: PC<=A → FETCH.
- HALT: absorbing state. No memory requests; only `reset` exits it.
- Writes to r0 are dropped; r0 always reads 0.
- Arithmetic is 32-bit with wrap-around. add/addi raise no overflow trap.
- `mem_addr` low bits are passed through unchecked; there is no alignment trap.

## Timing
- Reset values: state FETCH, PC=`RESET_PC`, `mem_re`=1, `mem_we`=0, `mem_addr`=`RESET_PC`, `mem_wdata`=0, `illegal`=0, counters 0.
- The first fetch request is visible in the first cycle after `reset` deasserts.
- Memory outputs are decoded from state and registers only (Moore); no combinational path from `mem_ready` or `mem_rdata`.
- While waiting, `mem_addr`, `mem_wdata`, `mem_re` and `mem_we` stay stable until the cycle `mem_ready`=1 is sampled.
- `mem_ready` outside FETCH, MEMRD and MEMWR is ignored.
- `mem_re` and `mem_we` are never high together.
- Latency with zero-wait memory (`mem_ready` tied 1):
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, jal, jr: 3 cycles.
- Each wait cycle adds 1.
- Reset asserted mid-instruction aborts it immediately. No partial register-file write is committed after the reset edge.

## Configuration
- `MC_PROC_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every cycle out of reset, including in HALT.
  - `instret_cnt` increments on every transition into FETCH from a non-FETCH state. Illegal NOPs count; HALT entry does not.
  - Both wrap at 2^32.
- Not defined: both ports and all counter logic are absent.

## Structure
- `mc_proc_pkg`: state enum, opcode and funct constants, 4-bit ALUControl codes shared with `alu`.
- Sub-module `mc_control_fsm`: state register, next-state logic and control strobes.
- The datapath stays in `mc_processor`, instantiating the existing `alu` and `register_block`.

## Test plan
- Reset with `RESET_PC`=0x100 → `mem_addr`=0x100, `mem_re`=1 during reset and in the first cycle after release. After fetching addi r1,r0,5, r1=5 at cycle 4.
- lw r2,8(r0) with memory word 8=0xDEADBEEF and `mem_ready` low for 3 cycles during MEMRD → r2=0xDEADBEEF after 8 cycles; address held at 8 throughout.
- sw r2,12(r0) → exactly one write cycle with `mem_we`=1, `mem_addr`=12, `mem_wdata`=0xDEADBEEF. `mem_re` stays 0 during it.
- beq r1,r1,-1 at PC 0x104 → next fetch at 0x104. With r1≠r3, beq r1,r3 falls through to 0x108.
- jal 0x40 at PC 0x200 → r31=0x204, next fetch 0x100. jr r31 → next fetch 0x204.
- Opcode 0x3F with `HALT_ON_ILLEGAL`=1 → `illegal`=1, no further requests, and `instret_cnt` frozen while `cycle_cnt` keeps counting (with `MC_PROC_PERF_CNT_EN`). Asserting `reset` clears `illegal` and restarts at `RESET_PC`.
